// File: rtl/s4_updown_counter_prog.sv
// Programmable N-bit up/down counter with terminal value, wrap/saturate/one-shot modes and an enable prescaler.
// Optional macro STICKY_THRESHOLD_EN turns the threshold flag into a sticky register cleared by thr_clear.
module s4_updown_counter_prog #(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         dec,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic [N-1:0] limit,
  input  logic [1:0]   mode,
  input  logic [N-1:0] threshold_value,
  input  logic         thr_clear,
  output logic [N-1:0] counterN,
  output logic         threshold,
  output logic         wrap_pulse,
  output logic         done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [N-1:0]  r_count;
  logic [PW-1:0] r_presc;
  logic          r_wrap;
  logic          r_done;

  logic [N-1:0]  w_limit_eff;
  logic [N-1:0]  w_load_clamped;
  logic          w_tick;
  logic          w_cmp;

  // A limit of zero selects the full 2^N-1 range.
  assign w_limit_eff    = (limit == '0) ? '1 : limit;
  assign w_load_clamped = (load_value > w_limit_eff) ? w_limit_eff : load_value;
  // With PRESCALE=1 the prescaler never leaves 0, so tick reduces to enable.
  assign w_tick         = enable & (r_presc == PW'(PRESCALE - 1));
  assign w_cmp          = (r_count >= threshold_value);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_presc <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (enable) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      if (w_tick && !r_done) begin
        if (!dec) begin
          // Counts above a lowered limit are treated as terminal on the way up.
          if (r_count < w_limit_eff) begin
            r_count <= r_count + 1'b1;
          end else if (mode == MODE_SAT) begin
            r_count <= w_limit_eff;
          end else if (mode == MODE_ONESHOT) begin
            r_done <= 1'b1;
          end else begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end
        end else begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else if (mode == MODE_ONESHOT) begin
            r_done <= 1'b1;
          end else if (mode != MODE_SAT) begin
            r_count <= w_limit_eff;
            r_wrap  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef STICKY_THRESHOLD_EN
  logic r_thr;

  // Set has priority over clear; load leaves the flag untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_thr <= 1'b0;
    end else if (w_cmp) begin
      r_thr <= 1'b1;
    end else if (thr_clear) begin
      r_thr <= 1'b0;
    end
  end

  assign threshold = r_thr;
`else
  logic w_unused_clear;
  assign w_unused_clear = thr_clear;
  assign threshold      = w_cmp;
`endif

  assign counterN   = r_count;
  assign wrap_pulse = r_wrap;
  assign done       = r_done;

endmodule

// File: tb/tb_s4_updown_counter_prog.sv
// Directed bench for s4_updown_counter_prog: N=4 with PRESCALE=1 (main DUT) and PRESCALE=3 (prescaler DUT).
module tb_s4_updown_counter_prog;

  localparam int N = 4;
  localparam int THR = 6;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         dec;
  logic         load;
  logic [N-1:0] load_value;
  logic [N-1:0] limit;
  logic [1:0]   mode;
  logic [N-1:0] threshold_value;
  logic         thr_clear;

  logic [N-1:0] counterN, counterN3;
  logic         threshold, threshold3;
  logic         wrap_pulse, wrap_pulse3;
  logic         done, done3;

  int n_checks = 0;
  int n_errors = 0;
  int e_cnt    = 0;
  bit e_stk    = 0;

  s4_updown_counter_prog #(.N(N), .PRESCALE(1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .dec(dec), .load(load),
    .load_value(load_value), .limit(limit), .mode(mode),
    .threshold_value(threshold_value), .thr_clear(thr_clear),
    .counterN(counterN), .threshold(threshold), .wrap_pulse(wrap_pulse), .done(done)
  );

  s4_updown_counter_prog #(.N(N), .PRESCALE(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable), .dec(dec), .load(load),
    .load_value(load_value), .limit(limit), .mode(mode),
    .threshold_value(threshold_value), .thr_clear(thr_clear),
    .counterN(counterN3), .threshold(threshold3), .wrap_pulse(wrap_pulse3), .done(done3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // One clock edge on the main DUT, then check count, wrap, done and threshold.
  task automatic step(input string tag, input int ec, input bit ew, input bit ed);
    bit cmp;
    bit exp_thr;
    cmp = (e_cnt >= THR);
    if (cmp) e_stk = 1'b1;
    else if (thr_clear) e_stk = 1'b0;
    @(posedge clock);
    #1;
    e_cnt = ec;
`ifdef STICKY_THRESHOLD_EN
    exp_thr = e_stk;
`else
    exp_thr = (ec >= THR);
`endif
    chk({tag, ".cnt"}, 32'(counterN), 32'(ec));
    chk({tag, ".wrap"}, 32'(wrap_pulse), 32'(ew));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".thr"}, 32'(threshold), 32'(exp_thr));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dec = 1'b0; load = 1'b0; load_value = '0;
    limit = '0; mode = 2'b00; threshold_value = N'(THR); thr_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.cnt", 32'(counterN), 0);
    chk("reset.wrap", 32'(wrap_pulse), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.thr", 32'(threshold), 0);
    reset = 1'b0;

    // Full-range wrap count 0..15 -> 0, pulse only on the wrapped cycle.
    enable = 1'b1;
    for (int k = 1; k <= 18; k++) step($sformatf("wrap%0d", k), k % 16, k == 16, 1'b0);
    // Now at 2. Clear attempt below threshold, then held clear across crossing.
    thr_clear = 1'b1;
    step("clr_lo", 3, 1'b0, 1'b0);
    for (int k = 4; k <= 8; k++) step($sformatf("clr_hi%0d", k), k, 1'b0, 1'b0);
    thr_clear = 1'b0;

    // Saturate at limit 9 up, then at 0 down.
    limit = 4'd9; mode = 2'b01; load = 1'b1; load_value = 4'd0;
    step("sat_ld", 0, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 12; k++) step($sformatf("sat_up%0d", k), (k > 9) ? 9 : k, 1'b0, 1'b0);
    dec = 1'b1;
    for (int k = 1; k <= 12; k++) step($sformatf("sat_dn%0d", k), (9 - k < 0) ? 0 : 9 - k, 1'b0, 1'b0);

    // One-shot countdown from 3.
    mode = 2'b10; load = 1'b1; load_value = 4'd3;
    step("os_ld", 3, 1'b0, 1'b0);
    load = 1'b0;
    step("os_2", 2, 1'b0, 1'b0);
    step("os_1", 1, 1'b0, 1'b0);
    step("os_0", 0, 1'b0, 1'b0);
    step("os_done", 0, 1'b0, 1'b1);
    step("os_hold1", 0, 1'b0, 1'b1);
    dec = 1'b0;
    step("os_hold2", 0, 1'b0, 1'b1);
    load = 1'b1; load_value = 4'd5;
    step("os_reload", 5, 1'b0, 1'b0);

    // Load beats a simultaneous tick and is clamped to limit_eff.
    mode = 2'b00; load_value = 4'd14;
    step("clamp", 9, 1'b0, 1'b0);

    // Limit lowered below the count: down decrements, up is terminal.
    limit = 4'd0; load_value = 4'd12;
    step("hi_ld", 12, 1'b0, 1'b0);
    load = 1'b0; limit = 4'd9; dec = 1'b1;
    step("hi_dn", 11, 1'b0, 1'b0);
    dec = 1'b0;
    step("hi_up_wrap", 0, 1'b1, 1'b0);
    step("hi_up_next", 1, 1'b0, 1'b0);
    dec = 1'b1;
    step("dn_1", 0, 1'b0, 1'b0);
    step("dn_wrap", 9, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    limit = 4'd0; dec = 1'b0;
    step("pre_rst", 10, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("async_rst.cnt", 32'(counterN), 0);
    chk("async_rst.cnt3", 32'(counterN3), 0);
    chk("async_rst.thr", 32'(threshold), 0);
    @(posedge clock);
    #1;
    reset = 1'b0; e_cnt = 0; e_stk = 1'b0;

    // Prescaler DUT: enable pattern 1,1,0,1 gives one step.
    load = 1'b1; load_value = 4'd0; enable = 1'b0;
    @(posedge clock); #1;
    load = 1'b0;
    enable = 1'b1; @(posedge clock); #1; chk("ps_e1", 32'(counterN3), 0);
    enable = 1'b1; @(posedge clock); #1; chk("ps_e2", 32'(counterN3), 0);
    enable = 1'b0; @(posedge clock); #1; chk("ps_off", 32'(counterN3), 0);
    enable = 1'b1; @(posedge clock); #1; chk("ps_e3", 32'(counterN3), 1);
    @(posedge clock); #1; chk("ps_mid", 32'(counterN3), 1);
    load = 1'b1; load_value = 4'd4;
    @(posedge clock); #1; chk("ps_ld", 32'(counterN3), 4);
    load = 1'b0;
    @(posedge clock); #1; chk("ps_r1", 32'(counterN3), 4);
    @(posedge clock); #1; chk("ps_r2", 32'(counterN3), 4);
    @(posedge clock); #1; chk("ps_r3", 32'(counterN3), 5);
    chk("ps_wrap", 32'(wrap_pulse3), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
